// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: issues SubBytes/ShiftRows/MixColumns/AddRoundKey enables in round order.
// Optional step watchdog compiled in with AES_CTRL_WATCHDOG_EN.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    input  logic       sub_done,
    input  logic       shift_done,
    input  logic       mix_done,
    input  logic       ark_done,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // state       | meaning
    // IDLE        | waiting for start, round = 0
    // ISSUE_ARK0  | pulse ark_en for the initial key whitening
    // WAIT_ARK0   | wait for ark_done of round 0
    // ISSUE_SUB   | pulse sub_en
    // WAIT_SUB    | wait for sub_done
    // ISSUE_SHIFT | pulse shift_en
    // WAIT_SHIFT  | wait for shift_done
    // ISSUE_MIX   | pulse mix_en (rounds 1..NR-1 only)
    // WAIT_MIX    | wait for mix_done
    // ISSUE_ARK   | pulse ark_en
    // WAIT_ARK    | wait for ark_done
    // FINISH      | ciphertext valid, done pulse
    typedef enum logic [3:0] {
        IDLE,
        ISSUE_ARK0,
        WAIT_ARK0,
        ISSUE_SUB,
        WAIT_SUB,
        ISSUE_SHIFT,
        WAIT_SHIFT,
        ISSUE_MIX,
        WAIT_MIX,
        ISSUE_ARK,
        WAIT_ARK,
        FINISH
    } state_t;

    localparam logic [3:0] NR_W = 4'(NR);

    if (NR < 2 || NR > 14) begin : g_bad_nr
        $error("aes_round_ctrl: NR out of range 2..14");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("aes_round_ctrl: TIMEOUT must be at least 1");
    end

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       sub_en_q, sub_en_d;
    logic       shift_en_q, shift_en_d;
    logic       mix_en_q, mix_en_d;
    logic       ark_en_q, ark_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       waiting;
    logic       step_ok;

`ifdef AES_CTRL_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        waiting = 1'b0;
        step_ok = 1'b0;
        case (state_q)
            IDLE: begin
                round_d = '0;
                if (start) state_d = ISSUE_ARK0;
            end
            ISSUE_ARK0:  state_d = WAIT_ARK0;
            WAIT_ARK0: begin
                waiting = 1'b1;
                step_ok = ark_done;
                if (ark_done) begin
                    state_d = ISSUE_SUB;
                    round_d = 4'd1;
                end
            end
            ISSUE_SUB:   state_d = WAIT_SUB;
            WAIT_SUB: begin
                waiting = 1'b1;
                step_ok = sub_done;
                if (sub_done) state_d = ISSUE_SHIFT;
            end
            ISSUE_SHIFT: state_d = WAIT_SHIFT;
            WAIT_SHIFT: begin
                waiting = 1'b1;
                step_ok = shift_done;
                // Final round skips MixColumns.
                if (shift_done) state_d = (round_q < NR_W) ? ISSUE_MIX : ISSUE_ARK;
            end
            ISSUE_MIX:   state_d = WAIT_MIX;
            WAIT_MIX: begin
                waiting = 1'b1;
                step_ok = mix_done;
                if (mix_done) state_d = ISSUE_ARK;
            end
            ISSUE_ARK:   state_d = WAIT_ARK;
            WAIT_ARK: begin
                waiting = 1'b1;
                step_ok = ark_done;
                if (ark_done) begin
                    if (round_q == NR_W) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE_SUB;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                round_d = '0;
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase

`ifdef AES_CTRL_WATCHDOG_EN
        // Counter is zero on every WAIT entry because ISSUE and done-advance both clear it.
        wd_d    = '0;
        error_d = 1'b0;
        if (waiting && !step_ok) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                round_d = '0;
                error_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif

        sub_en_d   = (state_d == ISSUE_SUB);
        shift_en_d = (state_d == ISSUE_SHIFT);
        mix_en_d   = (state_d == ISSUE_MIX);
        ark_en_d   = (state_d == ISSUE_ARK0) || (state_d == ISSUE_ARK);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            sub_en_q   <= 1'b0;
            shift_en_q <= 1'b0;
            mix_en_q   <= 1'b0;
            ark_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef AES_CTRL_WATCHDOG_EN
            wd_q       <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            sub_en_q   <= sub_en_d;
            shift_en_q <= shift_en_d;
            mix_en_q   <= mix_en_d;
            ark_en_q   <= ark_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef AES_CTRL_WATCHDOG_EN
            wd_q       <= wd_d;
            error_q    <= error_d;
`endif
        end
    end

    assign sub_en   = sub_en_q;
    assign shift_en = shift_en_q;
    assign mix_en   = mix_en_q;
    assign ark_en   = ark_en_q;
    assign round    = round_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef AES_CTRL_WATCHDOG_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: prompt/slow step models, start/spurious-done abuse, reset, stalled step.
module tb_aes_round_ctrl;
    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       sub_en, shift_en, mix_en, ark_en;
    logic       sub_done, shift_done, mix_done, ark_done;
    logic [3:0] round;
    logic       busy, done, error;

    aes_round_ctrl #(.NR(NR), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .sub_en(sub_en), .shift_en(shift_en), .mix_en(mix_en), .ark_en(ark_en),
        .sub_done(sub_done), .shift_done(shift_done), .mix_done(mix_done), .ark_done(ark_done),
        .round(round), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Step unit models: done returns dly cycles after the enable cycle.
    int         sub_dly = 1, shift_dly = 1, mix_dly = 1, ark_dly = 1;
    logic [7:0] sub_sr, shift_sr, mix_sr, ark_sr;
    logic       mix_force = 1'b0;
    logic       ark_hold = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            sub_sr <= '0; shift_sr <= '0; mix_sr <= '0; ark_sr <= '0;
        end else begin
            sub_sr   <= {sub_sr[6:0], sub_en};
            shift_sr <= {shift_sr[6:0], shift_en};
            mix_sr   <= {mix_sr[6:0], mix_en};
            ark_sr   <= {ark_sr[6:0], ark_en};
        end
    end

    assign sub_done   = sub_sr[sub_dly-1];
    assign shift_done = shift_sr[shift_dly-1];
    assign mix_done   = mix_sr[mix_dly-1] | mix_force;
    assign ark_done   = ark_sr[ark_dly-1] & ~(ark_hold && round == 4'd3);

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-run observations
    int          done_cyc, done_cnt, busy_first, busy_last, busy_cnt;
    int          err_cnt, err_cyc, multi_en, bad_mix, round_max, mix_cnt;
    logic [10:0] snap;
    logic [7:0]  en_q[$];
    logic [7:0]  exp_seq[$];

    function automatic logic [10:0] outs();
        return {sub_en, shift_en, mix_en, ark_en, busy, done, error, round};
    endfunction

    task automatic run(input int budget, input int p1, input int p2, input int spur,
                       input int rst_at, input int snap_at);
        logic [3:0] en;
        done_cyc = 0; done_cnt = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
        err_cnt = 0; err_cyc = 0; multi_en = 0; bad_mix = 0; round_max = 0; mix_cnt = 0;
        snap = '1;
        en_q.delete();
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start = 1'b0; rst = 1'b0; mix_force = 1'b0;
            en = {sub_en, shift_en, mix_en, ark_en};
            if ($countones(en) > 1) multi_en++;
            if (en != 4'b0) en_q.push_back({round, en});
            if (mix_en) begin
                mix_cnt++;
                if (round == 4'd0 || round == 4'(NR)) bad_mix++;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (error) begin
                err_cnt++;
                if (err_cyc == 0) err_cyc = c;
            end
            if (int'(round) > round_max) round_max = int'(round);
            if (c == snap_at) snap = outs();
            if (c == p1 || c == p2) start = 1'b1;
            if (c == spur) mix_force = 1'b1;
            if (c == rst_at) rst = 1'b1;
        end
    endtask

    function automatic int seq_errors();
        int n = 0;
        if (en_q.size() != exp_seq.size()) return -1;
        foreach (exp_seq[i]) if (en_q[i] !== exp_seq[i]) n++;
        return n;
    endfunction

    initial begin
        exp_seq.push_back({4'd0, 4'b0001});
        for (int r = 1; r <= NR; r++) begin
            exp_seq.push_back({4'(r), 4'b1000});
            exp_seq.push_back({4'(r), 4'b0100});
            if (r < NR) exp_seq.push_back({4'(r), 4'b0010});
            exp_seq.push_back({4'(r), 4'b0001});
        end

        // Reset with start asserted: rst wins
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(outs()), 32'd0);

        // Normal run, prompt step units
        run(100, -1, -1, -1, -1, -1);
        check("norm_done_cyc", done_cyc, 81);
        check("norm_done_cnt", done_cnt, 1);
        check("norm_busy_first", busy_first, 1);
        check("norm_busy_last", busy_last, 81);
        check("norm_busy_cnt", busy_cnt, 81);
        check("norm_mix_cnt", mix_cnt, 9);
        check("norm_seq_len", en_q.size(), 40);
        check("norm_seq_err", seq_errors(), 0);
        check("norm_multi_en", multi_en, 0);
        check("norm_bad_mix", bad_mix, 0);
        check("norm_round_max", round_max, 10);
        check("norm_error", err_cnt, 0);
        check("norm_end_idle", 32'(outs()), 32'd0);

        // Slow MixColumns: +2 cycles per round 1..9
        mix_dly = 3;
        run(120, -1, -1, -1, -1, -1);
        check("slowmix_done_cyc", done_cyc, 99);
        check("slowmix_done_cnt", done_cnt, 1);
        check("slowmix_busy_cnt", busy_cnt, 99);
        check("slowmix_seq_err", seq_errors(), 0);
        mix_dly = 1;

        // Slow SubBytes, start re-pulsed at 5 and 81, spurious mix_done in WAIT_SUB
        sub_dly = 3;
        run(130, 5, 81, 5, -1, 6);
        check("spur_snap_c6", 32'(snap), 32'(11'b0000_1_0_0_0001));
        check("spur_done_cyc", done_cyc, 101);
        check("spur_done_cnt", done_cnt, 1);
        check("spur_busy_cnt", busy_cnt, 101);
        check("spur_seq_err", seq_errors(), 0);
        sub_dly = 1;
        run(90, -1, -1, -1, -1, -1);
        check("rerun_done_cyc", done_cyc, 81);

        // Reset mid-run
        run(60, -1, -1, -1, 40, 41);
        check("rst_snap_c41", 32'(snap), 32'd0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_busy_last", busy_last, 40);
        run(90, -1, -1, -1, -1, -1);
        check("rst_fresh_done_cyc", done_cyc, 81);
        check("rst_fresh_seq_err", seq_errors(), 0);

        // ark_done withheld in round 3
        ark_hold = 1'b1;
        run(200, -1, -1, -1, -1, -1);
        check("stall_done_cnt", done_cnt, 0);
`ifdef AES_CTRL_WATCHDOG_EN
        check("stall_err_cnt", err_cnt, 1);
        check("stall_err_cyc", err_cyc, 41);
        check("stall_busy_last", busy_last, 40);
        check("stall_round", 32'(round), 32'd0);
`else
        check("stall_err_cnt", err_cnt, 0);
        check("stall_busy_last", busy_last, 200);
        check("stall_round", 32'(round), 32'd3);
`endif
        ark_hold = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("stall_recover", 32'(outs()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption through the single-cycle step units: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Each step unit uses the team's step protocol: one-cycle `enable` in, registered `done` returned on the following cycle.
- The controller issues enables in the AES round order and skips MixColumns in the final round.
- It drives the round index to the key schedule and data-path muxes, then reports completion.

Parameters:
- NR, 10, number of AES rounds (10 for AES-128); legal range 2..14.
- TIMEOUT, 15, cycles to wait for a step done before the watchdog fires (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin an encryption; sampled only in IDLE
- sub_en  out  1  SubBytes enable, one-cycle pulse
- shift_en  out  1  ShiftRows enable, one-cycle pulse
- mix_en  out  1  MixColumns enable, one-cycle pulse
- ark_en  out  1  AddRoundKey enable, one-cycle pulse
- sub_done  in  1  SubBytes done
- shift_done  in  1  ShiftRows done
- mix_done  in  1  MixColumns done
- ark_done  in  1  AddRoundKey done
- round  out  4  current round index 0..NR; also selects the round key
- busy  out  1  high from the first issue cycle through the FINISH cycle
- done  out  1  one-cycle pulse when the ciphertext is valid at the AddRoundKey output
- error  out  1  watchdog timeout pulse; tied 0 when the watchdog is not compiled

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. rst has priority over start and over every done input.
- Outputs are Moore, decoded from the state register only. At most one *_en is high in any cycle.
- States: IDLE, ISSUE_ARK0, WAIT_ARK0, ISSUE_SUB, WAIT_SUB, ISSUE_SHIFT, WAIT_SHIFT, ISSUE_MIX, WAIT_MIX, ISSUE_ARK, WAIT_ARK, FINISH.
- IDLE: start=1 -> ISSUE_ARK0 with round=0. start=0 -> stay.
- ISSUE_x: asserts x_en for exactly one cycle, then goes unconditionally to WAIT_x.
- WAIT_x: x_done=1 -> next state. Otherwise hold with all enables 0.
- Done inputs other than the awaited one are ignored. Any done arriving in IDLE, ISSUE or FINISH is ignored.
- Step order:
  - WAIT_ARK0 -> ISSUE_SUB, round becomes 1.
  - WAIT_SUB -> ISSUE_SHIFT.
  - WAIT_SHIFT -> ISSUE_MIX if round<NR, else ISSUE_ARK.
  - WAIT_MIX -> ISSUE_ARK.
  - WAIT_ARK -> FINISH if round==NR, else ISSUE_SUB with round+1.
- Round counter: changes only on the transitions above and never exceeds NR. mix_en never asserts while round==NR or round==0.
- FINISH: done=1 and busy=1 for one cycle, then IDLE. round holds NR in FINISH and clears to 0 on entering IDLE.
- Latency with prompt step units (done one cycle after enable):
  - Each step takes 2 cycles; 4*NR steps total.
  - done is high in cycle 8*NR+1 after the edge that sampled start, i.e. cycle 81 for NR=10.
- start while busy: ignored; no queuing.
- start held high during FINISH: ignored. If still high in IDLE, a new run begins one cycle later.
- rst mid-operation: the next edge returns to IDLE with all outputs 0; no done pulse.

Optional Feature:
- Macro: AES_CTRL_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to each WAIT state and counts while waiting.
  - If it reaches TIMEOUT without the awaited done, the FSM goes to IDLE, error pulses for one cycle, and done is not asserted.
  - The counter is reset by rst.
- Not defined: no counter exists, error is constant 0, and WAIT states wait indefinitely.

Test Plan:
- Normal run (NR=10, step models return done 1 cycle after enable), start pulsed at cycle 0 -> enable sequence ark, then (sub, shift, mix, ark)x9, then sub, shift, ark; 9 mix_en pulses; done at cycle 81; round 0..10; busy high cycles 1..81.
- Slow MixColumns model (done 3 cycles after enable) -> each round 1..9 stretches by 2 cycles; done at cycle 99; no enable re-issued while waiting.
- start re-pulsed at cycles 5 and 81, plus spurious mix_done while in WAIT_SUB -> no restart and no state advance; second run starts after IDLE.
- rst asserted in cycle 40 -> next cycle all outputs 0 and round=0; no done; a fresh start afterwards completes in 81 cycles.
- With AES_CTRL_WATCHDOG_EN, TIMEOUT=15, ark_done withheld in round 3 -> error pulse 15 cycles into WAIT_ARK, FSM back in IDLE, done stays 0. Without the macro, error stays 0 and the FSM waits indefinitely.
